// File: rtl/icache_if.sv
// ---------------------------------------------------------------------------
// icache_if
//   Groups the instruction-fetch request/response signals and the memory
//   controller instruction port used by the icache.
//
//   Fetch side : imemREN, imemaddr (request)  -> ihit, imemload (response)
//   Memory side: iREN, iaddr (read request)   <- iwait, iload (fill data)
//
//   slave  : the cache's view (consumes requests, drives responses/reads)
//   master : the environment's view (fetch stage + memory controller)
// ---------------------------------------------------------------------------
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
//   Direct-mapped, read-only instruction cache, one 32-bit word per frame.
//   Hits are answered combinationally in the same cycle; a miss latches the
//   word address, issues a single-word read to memory and fills the frame
//   in the first FETCH cycle with iwait low. The word then hits in the
//   following IDLE cycle.
//
//   Ports:
//     CLK        rising-edge clock
//     nRST       asynchronous active-low reset
//     bus        icache_if.slave: imemREN/imemaddr in, ihit/imemload out,
//                iREN/iaddr out, iwait/iload in
//     hit_count  saturating count of cycles with ihit=1
//     miss_count saturating count of misses (IDLE->FETCH transitions)
// ---------------------------------------------------------------------------
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  icache_if.slave          bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state;
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS];
  logic [29:0]       miss_addr;   // {tag, idx} of the outstanding miss
  logic              iren_r;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              hit;
  logic              fill;
  logic              unused_offset;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign req_idx  = bus.imemaddr[IDX_W+1:2];
  assign req_tag  = bus.imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W-1:0];
  assign miss_tag = miss_addr[29:IDX_W];

  // Byte offset within the word is irrelevant for word fetches.
  assign unused_offset = ^bus.imemaddr[1:0];

  // Lookups are suppressed during FETCH so a redirected fetch cannot hit
  // while the memory read for the older miss is still in flight.
  assign hit  = (state == IDLE) && bus.imemREN && valid[req_idx] &&
                (tag_mem[req_idx] == req_tag);
  assign fill = (state == FETCH) && !bus.iwait;

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? data_mem[req_idx] : 32'h0;
  assign bus.iREN     = iren_r;
  assign bus.iaddr    = {miss_addr, 2'b00};

  // Control state, valid bits and counters: cleared by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      miss_addr  <= '0;
      iren_r     <= 1'b0;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) hit_count <= sat_inc(hit_count);
      case (state)
        IDLE: begin
          if (bus.imemREN && !hit) begin
            miss_addr  <= bus.imemaddr[31:2];
            miss_count <= sat_inc(miss_count);
            iren_r     <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          // The read cannot be aborted: completes for the latched address
          // regardless of what the fetch stage is asking for now.
          if (!bus.iwait) begin
            valid[miss_idx] <= 1'b1;
            iren_r          <= 1'b0;
            state           <= IDLE;
          end
        end
        default: begin
          iren_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Tag/data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
//   Drives directed and randomized fetch traffic into two icache instances
//   (default 32-bit counters and a 4-bit counter build) and compares every
//   cycle against a behavioural model: a table of resident word addresses per
//   index, at most one outstanding miss, and unbounded hit/miss tallies that
//   are clamped to the counter width when compared.
// ---------------------------------------------------------------------------
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic [31:0] hc, mc;
  logic [3:0]  hc4, mc4;

  icache_if bus ();
  icache_if bus4 ();

  icache dut (
    .CLK(CLK), .nRST(nRST), .bus(bus), .hit_count(hc), .miss_count(mc)
  );

  icache #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .bus(bus4), .hit_count(hc4), .miss_count(mc4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0000_0044: return 32'h8C22_0004;
      32'h0000_0404: return 32'h2001_0005;
      default:       return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign bus.iload      = memword(bus.iaddr);
  assign bus4.iload     = memword(bus4.iaddr);
  assign bus4.imemREN   = bus.imemREN;
  assign bus4.imemaddr  = bus.imemaddr;
  assign bus4.iwait     = bus.iwait;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          mv    [16];
  logic [31:0] mline [16];   // word address resident in each frame
  bit          pend;
  logic [31:0] pend_addr;
  longint      hits, misses;

  function automatic logic [63:0] clamp(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  always @(negedge CLK) begin
    logic [31:0] wa;
    int          ix;
    bit          he;
    if (!nRST) begin
      foreach (mv[i]) mv[i] = 1'b0;
      pend   = 1'b0;
      hits   = 0;
      misses = 0;
      chk("rst_ihit",  bus.ihit,  1'b0);
      chk("rst_iREN",  bus.iREN,  1'b0);
      chk("rst_iaddr", bus.iaddr, 32'h0);
      chk("rst_hc",    hc,  32'h0);
      chk("rst_mc",    mc,  32'h0);
      chk("rst_iREN4", bus4.iREN, 1'b0);
      chk("rst_hc4",   hc4, 4'h0);
      chk("rst_mc4",   mc4, 4'h0);
    end else begin
      wa = {bus.imemaddr[31:2], 2'b00};
      ix = int'(wa[5:2]);
      he = !pend && bus.imemREN && mv[ix] && (mline[ix] == wa);
      chk("ihit",     bus.ihit,     he);
      chk("imemload", bus.imemload, he ? memword(wa) : 32'h0);
      chk("iREN",     bus.iREN,     pend);
      if (pend) chk("iaddr", bus.iaddr, pend_addr);
      chk("hit_count",  hc, clamp(hits,   64'hFFFF_FFFF));
      chk("miss_count", mc, clamp(misses, 64'hFFFF_FFFF));
      chk("ihit4",  bus4.ihit, he);
      chk("iREN4",  bus4.iREN, pend);
      chk("hit_count4",  hc4, clamp(hits,   15));
      chk("miss_count4", mc4, clamp(misses, 15));
      // advance the model across the coming rising edge
      if (he) hits++;
      if (!pend) begin
        if (bus.imemREN && !he) begin
          pend      = 1'b1;
          pend_addr = wa;
          misses++;
        end
      end else if (!bus.iwait) begin
        mv[int'(pend_addr[5:2])]    = 1'b1;
        mline[int'(pend_addr[5:2])] = pend_addr;
        pend = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST         = 1'b0;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0;
    bus.iwait    = 1'b0;
    cyc(); cyc(); #1;
    chk("t_rst_ihit", bus.ihit, 1'b0);
    chk("t_rst_iREN", bus.iREN, 1'b0);
    chk("t_rst_hc",   hc, 32'd0);
    chk("t_rst_mc",   mc, 32'd0);
    nRST = 1'b1;
    cyc(); #1;
    chk("t_rel_iREN",  bus.iREN,  1'b1);
    chk("t_rel_iaddr", bus.iaddr, 32'h0);
    chk("t_rel_mc",    mc,        32'd1);

    // cold miss on 0x44 with two wait cycles
    bus.imemaddr = 32'h44;
    cyc(); bus.iwait = 1'b1; #1;
    chk("t_cold_detect", bus.ihit, 1'b0);
    cyc(); #1;
    chk("t_cold_c1_iREN", bus.iREN, 1'b1);
    chk("t_cold_c1_addr", bus.iaddr, 32'h44);
    cyc(); #1;
    chk("t_cold_c2_addr", bus.iaddr, 32'h44);
    cyc(); bus.iwait = 1'b0; #1;
    chk("t_cold_c3_iREN", bus.iREN, 1'b1);
    chk("t_cold_c3_addr", bus.iaddr, 32'h44);
    cyc(); #1;
    chk("t_cold_hit",  bus.ihit, 1'b1);
    chk("t_cold_data", bus.imemload, 32'h8C22_0004);
    chk("t_cold_hc0",  hc, 32'd0);

    // conflict: 0x404 shares index 1 with 0x44
    cyc(); bus.imemaddr = 32'h404; #1;
    chk("t_cold_hc1",   hc, 32'd1);
    chk("t_conf_miss",  bus.ihit, 1'b0);
    chk("t_conf_mc2",   mc, 32'd2);
    cyc(); #1;
    chk("t_conf_iaddr", bus.iaddr, 32'h404);
    chk("t_conf_mc3",   mc, 32'd3);
    cyc(); #1;
    chk("t_conf_hit",  bus.ihit, 1'b1);
    chk("t_conf_data", bus.imemload, 32'h2001_0005);
    bus.imemaddr = 32'h44; #1;
    chk("t_thrash_miss", bus.ihit, 1'b0);
    cyc(); #1;
    chk("t_thrash_iaddr", bus.iaddr, 32'h44);
    chk("t_thrash_mc4",   mc, 32'd4);
    cyc(); #1;
    chk("t_thrash_hit", bus.imemload, 32'h8C22_0004);

    // redirect while a miss on 0x80 is outstanding
    bus.imemaddr = 32'h80; bus.iwait = 1'b1; #1;
    chk("t_redir_miss", bus.ihit, 1'b0);
    cyc(); #1;
    chk("t_redir_a0", bus.iaddr, 32'h80);
    bus.imemaddr = 32'h100; bus.imemREN = 1'b0;
    cyc(); #1;
    chk("t_redir_a1", bus.iaddr, 32'h80);
    bus.imemREN = 1'b1;
    cyc(); #1;
    chk("t_redir_a2", bus.iaddr, 32'h80);
    chk("t_redir_hold", bus.ihit, 1'b0);
    bus.iwait = 1'b0;
    cyc(); #1;
    chk("t_redir_idle", bus.iREN, 1'b0);
    bus.imemaddr = 32'h80; #1;
    chk("t_redir_fr0",   bus.ihit, 1'b1);
    chk("t_redir_fr0_d", bus.imemload, memword(32'h80));
    bus.imemaddr = 32'h100; #1;
    chk("t_redir_new_miss", bus.ihit, 1'b0);
    cyc(); #1;
    chk("t_redir_new_addr", bus.iaddr, 32'h100);

    // reset while FETCH is waiting
    bus.iwait = 1'b1;
    cyc(); #1;
    nRST = 1'b0; #1;
    chk("t_rstf_iREN",  bus.iREN,  1'b0);
    chk("t_rstf_iREN4", bus4.iREN, 1'b0);
    cyc(); cyc();
    nRST = 1'b1; bus.iwait = 1'b0; #1;
    chk("t_rstf_nohit", bus.ihit, 1'b0);
    cyc(); #1;
    chk("t_rstf_refetch", bus.iaddr, 32'h100);
    chk("t_rstf_mc",      mc, 32'd1);

    // randomized traffic over a small address pool
    for (int n = 0; n < 3000; n++) begin
      cyc();
      nRST         = ($urandom_range(0, 499) != 0);
      bus.imemREN  = ($urandom_range(0, 3) != 0);
      bus.imemaddr = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) |
                     $urandom_range(0, 3);
      bus.iwait    = ($urandom_range(0, 2) == 0);
    end

    // sustained hits: the 4-bit hit counter must pin at all-ones
    cyc();
    nRST = 1'b1; bus.imemREN = 1'b1; bus.iwait = 1'b0; bus.imemaddr = 32'h44;
    repeat (25) cyc();
    #1;
    chk("t_sat_ihit", bus.ihit, 1'b1);
    chk("t_sat_hc4",  hc4, 4'hF);
    cyc(); #1;
    chk("t_sat_hc4_hold", hc4, 4'hF);
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
